// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: shadow EX/MA/WB destination tags,
// per-port newest-result operand selection, one-bubble load-use stall and a saturating stall counter.
module fwd_hazard_unit #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned REGBITS  = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned WB_FWD   = 1,
  parameter int unsigned CNTW     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic                     ex_flush,
  input  logic                     id_valid,
  input  logic [REGBITS-1:0]       id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic [NREAD*REGBITS-1:0] id_rs,
  input  logic [NREAD-1:0]         id_rs_used,
  input  logic [NREAD*WIDTH-1:0]   rf_data,
  input  logic [WIDTH-1:0]         ex_data,
  input  logic [WIDTH-1:0]         ma_data,
  input  logic [WIDTH-1:0]         wb_data,
  output logic [NREAD*WIDTH-1:0]   fwd_data,
  output logic [NREAD*2-1:0]       fwd_src,
  output logic                     stall,
  output logic [CNTW-1:0]          stall_count
);

  localparam logic [REGBITS-1:0] ZR      = REGBITS'(ZERO_REG);
  localparam logic [1:0]         SRC_RF  = 2'd0;
  localparam logic [1:0]         SRC_WB  = 2'd1;
  localparam logic [1:0]         SRC_MA  = 2'd2;
  localparam logic [1:0]         SRC_EX  = 2'd3;

  typedef struct packed {
    logic               valid;
    logic [REGBITS-1:0] rd;
    logic               regwrite;
    logic               memread;
  } tag_t;

  tag_t            ex_q, ex_d, ma_q, ma_d, wb_q, wb_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ex_wr, ma_wr, wb_wr;
  logic            load_hit;

  assign ex_wr = ex_q.valid & ex_q.regwrite & (ex_q.rd != ZR);
  assign ma_wr = ma_q.valid & ma_q.regwrite & (ma_q.rd != ZR);
  assign wb_wr = wb_q.valid & wb_q.regwrite & (wb_q.rd != ZR) & (WB_FWD != 0);

  // Per-port operand selection, newest writer first; loads in EX only raise the hazard.
  always_comb begin
    fwd_data = '0;
    fwd_src  = '0;
    load_hit = 1'b0;
    for (int k = 0; k < int'(NREAD); k++) begin
      fwd_data[k*WIDTH +: WIDTH] = rf_data[k*WIDTH +: WIDTH];
      fwd_src[k*2 +: 2]          = SRC_RF;
      if (id_rs_used[k] && (id_rs[k*REGBITS +: REGBITS] != ZR)) begin
        if (ex_wr && !ex_q.memread && (ex_q.rd == id_rs[k*REGBITS +: REGBITS])) begin
          fwd_data[k*WIDTH +: WIDTH] = ex_data;
          fwd_src[k*2 +: 2]          = SRC_EX;
        end else if (ma_wr && (ma_q.rd == id_rs[k*REGBITS +: REGBITS])) begin
          fwd_data[k*WIDTH +: WIDTH] = ma_data;
          fwd_src[k*2 +: 2]          = SRC_MA;
        end else if (wb_wr && (wb_q.rd == id_rs[k*REGBITS +: REGBITS])) begin
          fwd_data[k*WIDTH +: WIDTH] = wb_data;
          fwd_src[k*2 +: 2]          = SRC_WB;
        end
        if (ex_wr && ex_q.memread && (ex_q.rd == id_rs[k*REGBITS +: REGBITS])) begin
          load_hit = 1'b1;
        end
      end
    end
    stall = id_valid & load_hit;
  end

  // Shadow pipeline advance and saturating stall counter.
  always_comb begin
    ex_d  = ex_q;
    ma_d  = ma_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!hold) begin
      wb_d = ma_q;
      ma_d = ex_q;
      if (stall || ex_flush || !id_valid) begin
        ex_d = '0;
      end else begin
        ex_d = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
      end
      if (stall && (cnt_q != {CNTW{1'b1}})) begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      ma_q  <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      ma_q  <= ma_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a default instance and a WB_FWD=0 / CNTW=3 instance
// share stimulus; expected values are queued on drive and popped at the sample point.
module tb_fwd_hazard_unit;

  localparam logic [63:0] RF0 = 64'hDEAD;
  localparam logic [63:0] RF1 = 64'hD1D1;
  localparam logic [63:0] EXD = 64'hBEEF;
  localparam logic [63:0] MAD = 64'hCAFE;
  localparam logic [63:0] WBD = 64'hF00D;

  localparam int S_F0 = 0, S_F1 = 1, S_S0 = 2, S_S1 = 3, S_ST = 4, S_CNT = 5;
  localparam int S_BF0 = 6, S_BS0 = 7, S_BCNT = 8, S_BST = 9;

  logic         clk = 1'b0;
  logic         reset, hold, ex_flush, id_valid, id_regwrite, id_memread;
  logic [4:0]   id_rd;
  logic [9:0]   id_rs;
  logic [1:0]   id_rs_used;
  logic [127:0] rf_data;
  logic [63:0]  ex_data, ma_data, wb_data;

  logic [127:0] fwd_data_a, fwd_data_b;
  logic [3:0]   fwd_src_a, fwd_src_b;
  logic         stall_a, stall_b;
  logic [31:0]  stall_count_a;
  logic [2:0]   stall_count_b;

  fwd_hazard_unit dut_a (
    .clk(clk), .reset(reset), .hold(hold), .ex_flush(ex_flush), .id_valid(id_valid),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .rf_data(rf_data), .ex_data(ex_data), .ma_data(ma_data),
    .wb_data(wb_data), .fwd_data(fwd_data_a), .fwd_src(fwd_src_a), .stall(stall_a),
    .stall_count(stall_count_a)
  );

  fwd_hazard_unit #(.WB_FWD(0), .CNTW(3)) dut_b (
    .clk(clk), .reset(reset), .hold(hold), .ex_flush(ex_flush), .id_valid(id_valid),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .rf_data(rf_data), .ex_data(ex_data), .ma_data(ma_data),
    .wb_data(wb_data), .fwd_data(fwd_data_b), .fwd_src(fwd_src_b), .stall(stall_b),
    .stall_count(stall_count_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      S_F0:    return fwd_data_a[63:0];
      S_F1:    return fwd_data_a[127:64];
      S_S0:    return 64'(fwd_src_a[1:0]);
      S_S1:    return 64'(fwd_src_a[3:2]);
      S_ST:    return 64'(stall_a);
      S_CNT:   return 64'(stall_count_a);
      S_BF0:   return fwd_data_b[63:0];
      S_BS0:   return 64'(fwd_src_b[1:0]);
      S_BCNT:  return 64'(stall_count_b);
      default: return 64'(stall_b);
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    q.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [63:0] obs;
    #1;
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = observe(e.sel);
      n_tests++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
    id_valid    = v;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_rs       = {rs1, rs0};
    id_rs_used  = used;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    hold     = 1'b0;
    ex_flush = 1'b0;
    rf_data  = {RF1, RF0};
    ex_data  = EXD;
    ma_data  = MAD;
    wb_data  = WBD;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    @(negedge clk);
    tick();
    reset = 1'b0;

    // Reset state
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 5'd3, 2'b11);
    push("rst_stall", S_ST, 0);   push("rst_src0", S_S0, 0);  push("rst_fwd0", S_F0, RF0);
    push("rst_src1", S_S1, 0);    push("rst_cnt", S_CNT, 0);  push("rst_cnt_b", S_BCNT, 0);
    check_all();

    // EX forwarding and EX > MA > WB priority
    drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01);
    push("ex_src0", S_S0, 3); push("ex_fwd0", S_F0, EXD); push("ex_stall", S_ST, 0);
    check_all();
    tick();
    tick();
    drive(1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd0, 2'b01);
    push("all3_src0", S_S0, 3); push("all3_fwd0", S_F0, EXD); push("all3_src0_b", S_BS0, 3);
    check_all();
    tick();
    drive(1'b1, 5'd9, 1'b0, 1'b0, 5'd3, 5'd4, 2'b11);
    push("ma_src0", S_S0, 2); push("ma_fwd0", S_F0, MAD);
    push("ex_src1", S_S1, 3); push("ex_fwd1", S_F1, EXD);
    check_all();
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 5'd4, 2'b11);
    push("wb_src0", S_S0, 1); push("wb_fwd0", S_F0, WBD);
    push("nowb_src0_b", S_BS0, 0); push("nowb_fwd0_b", S_BF0, RF0);
    push("ma_src1", S_S1, 2); push("ma_fwd1", S_F1, MAD);
    check_all();
    tick();

    // Zero register never forwarded; unused port neither forwards nor stalls
    drive(1'b1, 5'd31, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    tick(); tick(); tick();
    drive(1'b1, 5'd3, 1'b1, 1'b1, 5'd31, 5'd0, 2'b01);
    push("zr_src0", S_S0, 0); push("zr_fwd0", S_F0, RF0); push("zr_stall", S_ST, 0);
    check_all();
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd31, 5'd3, 2'b01);
    push("unused_src1", S_S1, 0); push("unused_fwd1", S_F1, RF1);
    push("unused_stall", S_ST, 0); push("zr2_src0", S_S0, 0);
    check_all();
    tick();

    // Load-use: one bubble, then operand from MA
    drive(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd7, 2'b11);
    push("lu_stall", S_ST, 1); push("lu_src0", S_S0, 0); push("lu_fwd0", S_F0, RF0);
    push("lu_src1", S_S1, 0); push("lu_cnt0", S_CNT, 0);
    check_all();
    tick();
    push("lu_stall_n1", S_ST, 0); push("lu_src0_n1", S_S0, 2); push("lu_fwd0_n1", S_F0, MAD);
    push("lu_cnt1", S_CNT, 1); push("lu_cnt1_b", S_BCNT, 1);
    check_all();
    tick();

    // Load followed by an independent instruction
    drive(1'b1, 5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd9, 5'd10, 2'b11);
    push("indep_stall", S_ST, 0); push("indep_stall_b", S_BST, 0);
    check_all();
    tick();

    // Hold during a stall freezes tags and counter; ex_flush ignored under hold
    drive(1'b1, 5'd12, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 5'd14, 1'b1, 1'b0, 5'd12, 5'd0, 2'b01);
    push("hold_pre_stall", S_ST, 1); push("hold_pre_cnt", S_CNT, 1);
    check_all();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex_flush = (i == 1);
      tick();
      push($sformatf("hold%0d_stall", i), S_ST, 1);
      push($sformatf("hold%0d_cnt", i), S_CNT, 1);
      push($sformatf("hold%0d_cnt_b", i), S_BCNT, 1);
      push($sformatf("hold%0d_src0", i), S_S0, 0);
      check_all();
    end
    hold     = 1'b0;
    ex_flush = 1'b0;
    tick();
    push("unhold_stall", S_ST, 0); push("unhold_src0", S_S0, 2); push("unhold_fwd0", S_F0, MAD);
    push("unhold_cnt", S_CNT, 2); push("unhold_cnt_b", S_BCNT, 2);
    check_all();

    // ex_flush turns a valid ID instruction into an EX bubble
    drive(1'b1, 5'd13, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
    ex_flush = 1'b1;
    tick();
    ex_flush = 1'b0;
    drive(1'b1, 5'd15, 1'b1, 1'b0, 5'd13, 5'd0, 2'b01);
    push("flush_src0", S_S0, 0); push("flush_fwd0", S_F0, RF0); push("flush_stall", S_ST, 0);
    check_all();
    tick();

    // Reset mid-stall
    drive(1'b1, 5'd20, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 5'd21, 1'b1, 1'b0, 5'd20, 5'd0, 2'b01);
    push("rms_stall_pre", S_ST, 1);
    check_all();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push("rms_stall", S_ST, 0); push("rms_cnt", S_CNT, 0); push("rms_cnt_b", S_BCNT, 0);
    push("rms_src0", S_S0, 0); push("rms_fwd0", S_F0, RF0);
    check_all();

    // Saturation of the 3-bit counter over 9 stall cycles
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 5'd21, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
      tick();
      drive(1'b1, 5'd22, 1'b1, 1'b0, 5'd21, 5'd0, 2'b01);
      push($sformatf("sat%0d_stall", i), S_ST, 1);
      push($sformatf("sat%0d_stall_b", i), S_BST, 1);
      check_all();
      tick();
      push($sformatf("sat%0d_cnt", i), S_CNT, 64'(i + 1));
      push($sformatf("sat%0d_cnt_b", i), S_BCNT, 64'((i + 1 > 7) ? 7 : i + 1));
      check_all();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
